// File: rtl/uart_pkg.sv
// Shared UART transmit types and constants.
// Provides the TX FSM state enum, idle line level and divisor width default.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam int   DIV_W_DEF     = 8;

endpackage

// File: rtl/bit_period_timer.sv
// Bit period timer: latches a period on load, counts down while run is high.
// Ports: CLK, NRST, load, run, clear, period_in -> tick (terminal count).
module bit_period_timer
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             load,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] period_in,
  output logic             tick
);

  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] cnt_q;

  assign tick = run & (cnt_q == '0);

  // Reload on terminal count so every bit lasts period+1 cycles.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      period_q <= period_in;
      cnt_q    <= period_in;
    end else if (tick) begin
      cnt_q <= period_q;
    end else if (run) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// TX frame sequencer: pops FIFO bytes and frames them start/data/stop on TX.
// Ports: CLK, NRST, enable, abort, baud_div, fifo_* , TX, busy, tx_idle, frame_done.
module tx_frame_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = DIV_W_DEF
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             enable,
  input  logic             abort,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [7:0]       fifo_data,
  output logic             TX,
  output logic             busy,
  output logic             tx_idle,
  output logic             frame_done
);

  localparam int CW = 3;

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 load;
  logic                 run;

  assign load = (state_q == LOAD);
  assign run  = (state_q == START) |
                (state_q == DATA)  |
                (state_q == STOP);

  bit_period_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .CLK      (CLK),
    .NRST     (NRST),
    .load     (load),
    .run      (run),
    .clear    (abort),
    .period_in(baud_div),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    fifo_rd    = 1'b0;
    frame_done = 1'b0;
    if (abort) begin
      state_d = IDLE;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Gated by NRST so no pop strobe leaks out while held in reset.
          if (NRST && enable && !fifo_empty) begin
            fifo_rd = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          shift_d = fifo_data[DATA_BITS-1:0];
          state_d = START;
        end
        START: begin
          if (tick) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (tick) begin
            shift_d = shift_q >> 1;
            if (bit_q == CW'(DATA_BITS - 1)) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_q == CW'(STOP_BITS - 1)) begin
              frame_done = 1'b1;
              state_d    = IDLE;
              bit_d      = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // TX is registered from the next state so the pin tracks state_q cleanly.
  always_comb begin
    tx_d = TX_IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= TX_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign TX      = tx_q;
  assign busy    = (state_q != IDLE);
  assign tx_idle = ~busy & fifo_empty;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer.
// FIFO model pushes expected frames on pop; a TX monitor pops and checks them.
module tb_tx_frame_sequencer;

  logic       CLK = 1'b0;
  logic       NRST = 1'b0;
  logic       enable = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] baud_div = 8'd0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'd0;
  logic       fifo_rd;
  logic       TX;
  logic       busy;
  logic       tx_idle;
  logic       frame_done;

  always #5 CLK = ~CLK;

  tx_frame_sequencer #(
    .DATA_BITS(8),
    .STOP_BITS(1),
    .DIV_W    (8)
  ) dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .enable    (enable),
    .abort     (abort),
    .baud_div  (baud_div),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_data (fifo_data),
    .TX        (TX),
    .busy      (busy),
    .tx_idle   (tx_idle),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0] data;
    int         per;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       ne;
  logic [7:0] fq[$];
  int         per_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int frames = 0;
  int rd_cyc = -1;
  int done_cyc = -1;
  bit rd_seen = 0;

  bit         m_act = 0;
  bit         m_abt = 0;
  int         m_c = 0;
  int         m_L = 1;
  logic [7:0] m_d = 8'd0;
  int         idx;
  logic       expb;
  logic       expd;
  bit         btb = 0;
  bit         have_prev = 0;
  int         prev_L = 0;
  int         hi_run = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("wait_frames", frames, n);
  endtask

  task automatic wait_pos(input int c, input int budget);
    int k = 0;
    @(posedge CLK);
    while (!(m_act && m_c == c) && k < budget) begin
      @(posedge CLK);
      k++;
    end
    chk("wait_pos", k < budget, 1);
  endtask

  // FIFO model: head is presented the cycle after the pop strobe.
  always @(posedge CLK) begin
    #1;
    if (rd_seen) begin
      rd_seen = 0;
      if (fq.size() > 0) begin
        fifo_data = fq.pop_front();
        ne.data = fifo_data;
        ne.per  = int'(baud_div) + 1;
        exp_q.push_back(ne);
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // Sampler and TX line monitor, all at the inactive edge.
  always @(negedge CLK) begin
    cyc++;
    if (NRST && fifo_rd) begin
      rd_seen = 1;
      rd_cyc  = cyc;
      pops++;
    end
    if (!NRST) begin
      m_act = 0;
      m_abt = 0;
    end else begin
      if (busy) chk("rd_in_frame", fifo_rd, 0);
      if (m_abt) begin
        chk("abort_tx", TX, 1);
        chk("abort_busy", busy, 0);
        m_abt = 0;
      end
      if (!m_act && TX == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexp_frame", 1, 0);
        end else begin
          ne    = exp_q.pop_front();
          m_d   = ne.data;
          m_L   = ne.per;
          m_act = 1;
          m_c   = 0;
          per_log.push_back(m_L);
          chk("start_lat", cyc - rd_cyc, 2);
          if (btb && have_prev) chk("gap", prev_L + hi_run, 3);
          have_prev = 0;
        end
      end
      if (m_act) begin
        idx = m_c / m_L;
        if (idx == 0) expb = 1'b0;
        else if (idx <= 8) expb = m_d[idx-1];
        else expb = 1'b1;
        expd = (m_c == 10 * m_L - 1) && !abort;
        chk("tx", TX, expb);
        chk("done", frame_done, expd);
        if (abort) begin
          m_act     = 0;
          m_abt     = 1;
          have_prev = 0;
        end else if (m_c == 10 * m_L - 1) begin
          m_act     = 0;
          frames++;
          done_cyc  = cyc;
          prev_L    = m_L;
          have_prev = 1;
          hi_run    = 0;
        end else begin
          m_c++;
        end
      end else begin
        chk("done_idle", frame_done, 0);
        if (TX) hi_run++;
      end
    end
  end

  initial begin
    // Reset held with a byte waiting and transmit enabled.
    NRST     = 1'b0;
    enable   = 1'b1;
    baud_div = 8'd3;
    push_byte(8'hA5);
    repeat (3) begin
      @(negedge CLK);
      chk("rst_tx", TX, 1);
      chk("rst_rd", fifo_rd, 0);
      chk("rst_busy", busy, 0);
    end
    @(posedge CLK);
    #2 NRST = 1'b1;

    // Single frame, 4-cycle bits.
    wait_frames(1, 200);
    chk("done_at_41", done_cyc - rd_cyc, 41);
    @(negedge CLK);
    chk("idle_after", tx_idle, 1);
    chk("pops_1", pops, 1);

    // Back-to-back, one cycle per bit.
    @(posedge CLK);
    #2;
    baud_div  = 8'd0;
    have_prev = 0;
    btb       = 1;
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(3, 200);
    btb = 0;
    chk("pops_3", pops, 3);

    // Abort in data bit 3 of 0x55, next byte must go out cleanly.
    @(posedge CLK);
    #2;
    baud_div = 8'd1;
    push_byte(8'h55);
    push_byte(8'h3C);
    wait_pos(8, 300);
    #2 abort = 1'b1;
    @(posedge CLK);
    #2 abort = 1'b0;
    wait_frames(4, 300);
    chk("pops_abort", pops, 5);

    // Divisor change mid-frame only affects the following frame.
    @(posedge CLK);
    #2;
    baud_div = 8'd2;
    push_byte(8'h81);
    push_byte(8'h7E);
    wait_pos(5, 300);
    #2 baud_div = 8'd7;
    wait_frames(6, 600);
    chk("nlog", per_log.size(), 7);
    if (per_log.size() == 7) begin
      chk("per_old", per_log[5], 3);
      chk("per_new", per_log[6], 8);
    end

    // Enable drop mid-frame with two bytes queued.
    @(posedge CLK);
    #2;
    baud_div = 8'd1;
    push_byte(8'h12);
    push_byte(8'h34);
    wait_pos(1, 300);
    #2 enable = 1'b0;
    wait_frames(7, 300);
    repeat (50) @(negedge CLK);
    chk("pops_en", pops, 8);
    chk("frames_en", frames, 7);
    chk("fifo_left", fifo_empty, 0);
    chk("tx_idle_q", tx_idle, 0);
    chk("busy_en", busy, 0);
    chk("exp_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
